// File: rtl/arq_gbn_tx_buffer.sv
// Go-back-N ARQ transmit buffer: DEPTH-entry frame store with a sliding send window,
// cumulative ACK, NACK rewind, timeout retransmission and a per-frame retry limit.
module arq_gbn_tx_buffer #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int WINDOW    = 4,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3,
    localparam int PW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              overflow,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic [PW-1:0]     tx_seq,
    input  logic              ack_valid,
    input  logic              ack_nack,
    input  logic [PW-1:0]     ack_seq,
    output logic [PW-1:0]     count,
    output logic              retry_err
);
    localparam int AW = PW - 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
    localparam logic [PW-1:0] WINDOW_P   = PW'(WINDOW);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     base;
    logic [PW-1:0]     nxt;
    logic [PW-1:0]     wr;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     retry;

    logic [PW-1:0]     in_flight;
    logic [PW-1:0]     resp_off;
    logic              wr_fire;
    logic              tx_fire;
    logic              resp_hit;
    logic              ack_hit;
    logic              nack_hit;
    logic              timeout_hit;

    logic [PW-1:0]     base_n;
    logic [PW-1:0]     nxt_n;
    logic [TW-1:0]     timer_n;
    logic [RW-1:0]     retry_n;
    logic [PW-1:0]     rewind_to;
    logic              bump;
    logic              drop;

    // All window tests use modular distances from base so sequence wrap is seamless.
    assign count     = wr - base;
    assign in_flight = nxt - base;
    assign resp_off  = ack_seq - base;
    assign full      = (count == DEPTH_P);
    assign tx_valid  = (nxt != wr) && (in_flight < WINDOW_P);
    assign tx_seq    = nxt;
    assign tx_data   = tx_valid ? mem[nxt[AW-1:0]] : '0;

    assign wr_fire     = wr_en && !full;
    assign tx_fire     = tx_valid && tx_ready;
    assign resp_hit    = ack_valid && (resp_off < in_flight);
    assign ack_hit     = resp_hit && !ack_nack;
    assign nack_hit    = resp_hit && ack_nack;
    assign timeout_hit = !resp_hit && (nxt != base) && (timer == TIMER_LAST);

    always_comb begin
        base_n    = base;
        nxt_n     = nxt;
        timer_n   = timer;
        retry_n   = retry;
        rewind_to = base;
        bump      = 1'b1;
        drop      = 1'b0;

        if (tx_fire) begin
            nxt_n = nxt + PW'(1);
        end

        if (ack_hit) begin
            base_n  = ack_seq + PW'(1);
            retry_n = '0;
            timer_n = '0;
        end else if (nack_hit || timeout_hit) begin
            // A rewind counts against the retry budget only when it lands on the current base.
            rewind_to = nack_hit ? ack_seq : base;
            bump      = !nack_hit || (ack_seq == base);
            timer_n   = '0;
            if (bump && (retry == RETRY_LAST)) begin
                drop    = 1'b1;
                base_n  = base + PW'(1);
                nxt_n   = base + PW'(1);
                retry_n = '0;
            end else begin
                base_n  = rewind_to;
                nxt_n   = rewind_to;
                retry_n = bump ? retry + RW'(1) : '0;
            end
        end else if (nxt != base) begin
            timer_n = timer + TW'(1);
        end else begin
            timer_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base      <= '0;
            nxt       <= '0;
            wr        <= '0;
            timer     <= '0;
            retry     <= '0;
            overflow  <= 1'b0;
            retry_err <= 1'b0;
        end else begin
            base      <= base_n;
            nxt       <= nxt_n;
            timer     <= timer_n;
            retry     <= retry_n;
            retry_err <= drop;
            if (wr_fire) begin
                wr <= wr + PW'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_arq_gbn_tx_buffer.sv
// Bench for arq_gbn_tx_buffer: directed scenarios plus random traffic, checked every
// cycle against an absolute-index queue model of the go-back-N rules.
module tb_arq_gbn_tx_buffer;
    localparam int DATA_W    = 4;
    localparam int DEPTH     = 8;
    localparam int WINDOW    = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;
    localparam int PW        = $clog2(DEPTH) + 1;
    localparam int SEQ_MOD   = 1 << PW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              full;
    logic              overflow;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] tx_data;
    logic [PW-1:0]     tx_seq;
    logic              ack_valid = 1'b0;
    logic              ack_nack = 1'b0;
    logic [PW-1:0]     ack_seq = '0;
    logic [PW-1:0]     count;
    logic              retry_err;

    arq_gbn_tx_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .WINDOW(WINDOW),
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .overflow(overflow), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_seq(tx_seq), .ack_valid(ack_valid), .ack_nack(ack_nack),
        .ack_seq(ack_seq), .count(count), .retry_err(retry_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Model keeps unbounded frame indices; pend holds payloads of frames base..wr-1.
    int m_base, m_nxt, m_wr, m_timer, m_retry;
    bit m_overflow, m_err;
    logic [DATA_W-1:0] pend[$];

    task automatic check_val(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_base = 0; m_nxt = 0; m_wr = 0; m_timer = 0; m_retry = 0;
        m_overflow = 1'b0; m_err = 1'b0;
        pend.delete();
    endfunction

    function automatic void drop_front(input int n);
        for (int i = 0; i < n; i++) void'(pend.pop_front());
        m_base += n;
    endfunction

    function automatic void model_rewind(input int target, input bit same_base);
        m_timer = 0;
        if (same_base && (m_retry + 1 > MAX_RETRY)) begin
            drop_front(1);
            m_nxt   = m_base;
            m_retry = 0;
            m_err   = 1'b1;
        end else begin
            drop_front(target - m_base);
            m_nxt   = target;
            m_retry = same_base ? m_retry + 1 : 0;
        end
    endfunction

    function automatic void model_step();
        int outstanding, off;
        bit full_pre, fire, resp;
        if (rst) begin
            model_reset();
            return;
        end
        outstanding = m_nxt - m_base;
        full_pre    = (m_wr - m_base) == DEPTH;
        fire        = (m_nxt != m_wr) && (outstanding < WINDOW) && tx_ready;
        off         = (int'(ack_seq) - (m_base % SEQ_MOD) + SEQ_MOD) % SEQ_MOD;
        resp        = ack_valid && (off < outstanding);
        m_err       = 1'b0;
        if (fire) m_nxt++;
        if (resp && !ack_nack) begin
            drop_front(off + 1);
            m_retry = 0;
            m_timer = 0;
        end else if (resp) begin
            model_rewind(m_base + off, off == 0);
        end else if (outstanding != 0) begin
            if (m_timer == TIMEOUT - 1) model_rewind(m_base, 1'b1);
            else m_timer++;
        end else begin
            m_timer = 0;
        end
        if (wr_en) begin
            if (full_pre) m_overflow = 1'b1;
            else begin
                pend.push_back(wr_data);
                m_wr++;
            end
        end
    endfunction

    task automatic check_output();
        bit exp_tv;
        exp_tv = (m_nxt != m_wr) && (m_nxt - m_base < WINDOW);
        check_val("count", int'(count), m_wr - m_base);
        check_val("full", int'(full), int'((m_wr - m_base) == DEPTH));
        check_val("overflow", int'(overflow), int'(m_overflow));
        check_val("tx_valid", int'(tx_valid), int'(exp_tv));
        check_val("tx_seq", int'(tx_seq), m_nxt % SEQ_MOD);
        if (exp_tv) check_val("tx_data", int'(tx_data), int'(pend[m_nxt - m_base]));
        check_val("retry_err", int'(retry_err), int'(m_err));
    endtask

    always @(negedge clk) begin
        if (chk_en) check_output();
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_stimulus(input bit w, input logic [DATA_W-1:0] d, input bit rdy,
                                  input bit av, input bit an, input logic [PW-1:0] as);
        wr_en = w; wr_data = d; tx_ready = rdy;
        ack_valid = av; ack_nack = an; ack_seq = as;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_count"}, int'(count), 0);
        check_val({tag, "_full"}, int'(full), 0);
        check_val({tag, "_overflow"}, int'(overflow), 0);
        check_val({tag, "_tx_valid"}, int'(tx_valid), 0);
        check_val({tag, "_tx_seq"}, int'(tx_seq), 0);
        check_val({tag, "_tx_data"}, int'(tx_data), 0);
        check_val({tag, "_retry_err"}, int'(retry_err), 0);
    endtask

    function automatic logic [PW-1:0] last_sent_seq();
        return PW'((m_nxt - 1) % SEQ_MOD);
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [PW-1:0]     got_seq[$];
        logic [DATA_W-1:0] got_data[$];
        int n;
        bit wrapped;
        int mute;

        model_reset();
        chk_en = 1'b1;
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four frames go out back to back, then the window is exhausted.
        apply_stimulus(1, 4'h0, 1, 0, 0, 0);
        check_val("s1_seq0", int'(tx_seq), 0);  check_val("s1_data0", int'(tx_data), 'h0);
        apply_stimulus(1, 4'hA, 1, 0, 0, 0);
        check_val("s1_seq1", int'(tx_seq), 1);  check_val("s1_data1", int'(tx_data), 'hA);
        apply_stimulus(1, 4'h3, 1, 0, 0, 0);
        check_val("s1_seq2", int'(tx_seq), 2);  check_val("s1_data2", int'(tx_data), 'h3);
        apply_stimulus(1, 4'h2, 1, 0, 0, 0);
        check_val("s1_seq3", int'(tx_seq), 3);  check_val("s1_data3", int'(tx_data), 'h2);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        check_val("s1_valid_off", int'(tx_valid), 0);
        check_val("s1_count", int'(count), 4);

        apply_stimulus(0, 4'h0, 1, 1, 0, 4'd1);
        check_val("s2_count_ack1", int'(count), 2);
        check_val("s2_valid", int'(tx_valid), 0);
        apply_stimulus(0, 4'h0, 1, 1, 0, 4'd3);
        check_val("s2_count_ack3", int'(count), 0);

        for (int i = 1; i <= 4; i++) apply_stimulus(1, DATA_W'(i), 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 0, 1, 1, 4'd5);
        check_val("s3_nack_seq", int'(tx_seq), 5);
        check_val("s3_nack_data", int'(tx_data), 2);
        check_val("s3_nack_count", int'(count), 3);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        check_val("s3_resend_seq", int'(tx_seq), 6);
        check_val("s3_resend_data", int'(tx_data), 3);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 0, 1, 0, 4'd7);
        check_val("s3_count_done", int'(count), 0);

        // One frame never answered: rewinds every 16 cycles, dropped on the 4th.
        apply_stimulus(1, 4'h9, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(0, 4'h0, 1, 0, 0, 0);
            n = 0;
            while (!(tx_valid || retry_err) && n < 40) begin
                apply_stimulus(0, 4'h0, 0, 0, 0, 0);
                n++;
            end
            check_val("s4_timeout_cycles", n, 16);
            check_val("s4_retry_err", int'(retry_err), (k == 4) ? 1 : 0);
        end
        check_val("s4_drop_count", int'(count), 0);
        check_val("s4_drop_seq", int'(tx_seq), 9);
        apply_stimulus(0, 4'h0, 0, 0, 0, 0);
        check_val("s4_err_pulse_end", int'(retry_err), 0);

        for (int i = 0; i < 9; i++) apply_stimulus(1, DATA_W'(i + 1), 0, 0, 0, 0);
        check_val("s5_full", int'(full), 1);
        check_val("s5_overflow", int'(overflow), 1);
        check_val("s5_count", int'(count), 8);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 1, 0, 0, 0);
        apply_stimulus(0, 4'h0, 0, 1, 0, 4'd7);
        check_val("s5_stale_count", int'(count), 8);
        apply_stimulus(1, 4'hF, 0, 1, 0, 4'd10);
        check_val("s5_ack_write_full_count", int'(count), 6);
        check_val("s5_full_cleared", int'(full), 0);

        n = 0;
        while (m_wr != m_base && n < 40) begin
            apply_stimulus(0, 4'h0, 1, m_nxt > m_base, 0, last_sent_seq());
            n++;
        end
        check_val("s6_drained", int'(count), 0);

        // Stream 20 frames from absolute index 17 (seq 1), acking each as it leaves.
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = DATA_W'(i); tx_ready = 1'b1;
            ack_valid = m_nxt > m_base; ack_nack = 1'b0; ack_seq = last_sent_seq();
            if (tx_valid) begin got_seq.push_back(tx_seq); got_data.push_back(tx_data); end
            tick();
        end
        n = 0;
        while (got_seq.size() < 20 && n < 20) begin
            wr_en = 1'b0; tx_ready = 1'b1;
            ack_valid = m_nxt > m_base; ack_seq = last_sent_seq();
            if (tx_valid) begin got_seq.push_back(tx_seq); got_data.push_back(tx_data); end
            tick();
            n++;
        end
        check_val("s6_frames", got_seq.size(), 20);
        wrapped = 1'b0;
        for (int i = 0; i < got_seq.size() && i < 20; i++) begin
            check_val("s6_data_order", int'(got_data[i]), i % 16);
            check_val("s6_seq_order", int'(got_seq[i]), (17 + i) % 16);
            if (i > 0 && got_seq[i] == 0 && got_seq[i-1] == 15) wrapped = 1'b1;
        end
        check_val("s6_seq_wrap", int'(wrapped), 1);

        for (int i = 0; i < 6; i++) apply_stimulus(1, DATA_W'(i), 1, 0, 0, 0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("midreset");
        tick();
        rst = 1'b0;

        mute = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 300 == 150) mute = 100;
            if (cyc == 1500) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
            wr_en    = $urandom_range(0, 99) < 55;
            wr_data  = DATA_W'($urandom);
            tx_ready = $urandom_range(0, 99) < 70;
            ack_valid = (mute == 0) && ($urandom_range(0, 99) < 35);
            ack_nack  = $urandom_range(0, 99) < 25;
            if (m_nxt > m_base && $urandom_range(0, 3) != 0)
                ack_seq = PW'((m_base + int'($urandom_range(0, m_nxt - m_base - 1))) % SEQ_MOD);
            else
                ack_seq = PW'($urandom_range(0, SEQ_MOD - 1));
            if (mute > 0) mute--;
            tick();
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
